// File: rtl/md_bus_arbiter.sv
// ---------------------------------------------------------------------------
// md_bus_arbiter
//
// DMA bus arbiter for the 68000 bus. Up to NREQ internal masters raise a
// level request; the arbiter runs the BR / BG / BGACK handshake with the CPU
// on their behalf and hands the bus to exactly one master at a time.
// Replaces the old fixed two-source BR/BGACK wired-AND in the top level.
//
// Parameters
//   NREQ       number of requesters (2..8)
//   PRIO_MODE  0 = fixed priority (lowest index wins), 1 = round-robin
//   TIMEOUT    maximum ownership in MCLK cycles, 0 disables the watchdog
//
// Ports
//   MCLK        in   system clock
//   SRES        in   asynchronous reset, active-low
//   REQ         in   per-master bus request, active-high level
//   BG          in   68000 bus grant, active-low, already synchronised
//   AS_i        in   68000 address strobe, active-low
//   BGACK_i     in   wired BGACK bus, active-low
//   BR_pull     out  1 = pull BR low
//   BGACK_pull  out  1 = pull BGACK low
//   GNT         out  one-hot grant to the owning master
//   BUSY        out  1 while the FSM is outside IDLE
//   TOUT        out  one-cycle pulse on the index revoked by the watchdog
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module md_bus_arbiter #(
  parameter int NREQ      = 4,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 0
) (
  input  logic            MCLK,
  input  logic            SRES,
  input  logic [NREQ-1:0] REQ,
  input  logic            BG,
  input  logic            AS_i,
  input  logic            BGACK_i,
  output logic            BR_pull,
  output logic            BGACK_pull,
  output logic [NREQ-1:0] GNT,
  output logic            BUSY,
  output logic [NREQ-1:0] TOUT
);

  // Index width for owner / round-robin pointer
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Watchdog counter width: max(1, clog2(TIMEOUT+1))
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_OWN  = 2'd2,
    S_REL  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            br_pull_q, br_pull_d;
  logic            bgack_pull_q, bgack_pull_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic [NREQ-1:0] tout_q, tout_d;

  logic [IW-1:0]   winner;
  logic            winner_found;
  logic [IW-1:0]   cand;
  logic [IW:0]     rr_sum;
  logic            owner_req;
  logic            cpu_grants;
  logic            wd_fire;
  logic [IW-1:0]   owner_next_ptr;

  // Winner selection. Fixed priority scans downward so the lowest set index
  // is the last one written. Round-robin scans upward from rr_ptr, wrapping
  // modulo NREQ, and keeps the first hit. rr_sum is one bit wider so the
  // wrap test works for NREQ that is not a power of two.
  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    cand         = '0;
    rr_sum       = '0;
    if (PRIO_MODE == 0) begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        cand = IW'(i);
        if (REQ[cand]) begin
          winner       = cand;
          winner_found = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        rr_sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
        if (rr_sum >= (IW+1)'(NREQ)) begin
          rr_sum = rr_sum - (IW+1)'(NREQ);
        end
        cand = rr_sum[IW-1:0];
        if (!winner_found && REQ[cand]) begin
          winner       = cand;
          winner_found = 1'b1;
        end
      end
    end
  end

  // Qualifiers shared by the FSM. The CPU has really let go of the bus only
  // when BG is low, no cycle is running (AS high) and no other master still
  // holds BGACK.
  always_comb begin
    owner_req      = REQ[owner_q];
    cpu_grants     = !BG && AS_i && BGACK_i;
    wd_fire        = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    owner_next_ptr = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
  end

  // Next-state and registered-output logic. Cancellation in ARB is tested
  // before the CPU grant so a simultaneous drop of REQ and arrival of BG
  // never produces a grant. In OWN, a normal release wins over the watchdog
  // so TOUT only pulses when the owner was still requesting.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    br_pull_d    = br_pull_q;
    bgack_pull_d = bgack_pull_q;
    gnt_d        = gnt_q;
    tout_d       = '0;

    case (state_q)
      S_IDLE: begin
        br_pull_d    = 1'b0;
        bgack_pull_d = 1'b0;
        gnt_d        = '0;
        if (winner_found) begin
          owner_d   = winner;
          br_pull_d = 1'b1;
          state_d   = S_ARB;
        end
      end

      S_ARB: begin
        br_pull_d = 1'b1;
        if (!owner_req) begin
          br_pull_d = 1'b0;
          state_d   = S_IDLE;
        end else if (cpu_grants) begin
          br_pull_d      = 1'b0;
          bgack_pull_d   = 1'b1;
          gnt_d          = '0;
          gnt_d[owner_q] = 1'b1;
          cnt_d          = '0;
          state_d        = S_OWN;
        end
      end

      S_OWN: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (!owner_req || wd_fire) begin
          bgack_pull_d = 1'b0;
          gnt_d        = '0;
          state_d      = S_REL;
          if (owner_req) begin
            tout_d[owner_q] = 1'b1;
          end
        end
      end

      S_REL: begin
        br_pull_d    = 1'b0;
        bgack_pull_d = 1'b0;
        gnt_d        = '0;
        rr_ptr_d     = owner_next_ptr;
        state_d      = S_IDLE;
      end

      default: begin
        br_pull_d    = 1'b0;
        bgack_pull_d = 1'b0;
        gnt_d        = '0;
        state_d      = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset clears everything asynchronously so
  // the pulls drop immediately even mid-ownership.
  always_ff @(posedge MCLK or negedge SRES) begin
    if (!SRES) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      br_pull_q    <= 1'b0;
      bgack_pull_q <= 1'b0;
      gnt_q        <= '0;
      busy_q       <= 1'b0;
      tout_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      br_pull_q    <= br_pull_d;
      bgack_pull_q <= bgack_pull_d;
      gnt_q        <= gnt_d;
      busy_q       <= busy_d;
      tout_q       <= tout_d;
    end
  end

  assign BR_pull    = br_pull_q;
  assign BGACK_pull = bgack_pull_q;
  assign GNT        = gnt_q;
  assign BUSY       = busy_q;
  assign TOUT       = tout_q;

`ifndef SYNTHESIS
  // Bus-protocol invariants
  a_gnt_onehot : assert property (@(posedge MCLK) disable iff (!SRES)
    $onehot0(gnt_q));
  a_gnt_bgack  : assert property (@(posedge MCLK) disable iff (!SRES)
    ((gnt_q != '0) == bgack_pull_q));
  a_pull_excl  : assert property (@(posedge MCLK) disable iff (!SRES)
    !(br_pull_q && bgack_pull_q));
`endif

endmodule

// File: doc/md_bus_arbiter.md
# md_bus_arbiter

Parametrised 68000-bus DMA arbiter for the FC1004-class integration: it collects bus requests from up to eight internal masters (VDP DMA, Z80 bank window, TMSS, expansion), runs the 68000 BR/BG/BGACK handshake on their behalf, and hands the bus to exactly one master at a time. It replaces the fixed two-source BR/BGACK wired-AND in the top level. It adds selectable priority, a grant-ownership watchdog and request cancellation, which the current top level does not have.

## Interface

Parameters:
- NREQ, 4, number of requesters, legal range 2..8
- PRIO_MODE, 0, arbitration policy: 0 = fixed priority (lowest index wins); 1 = round-robin
- TIMEOUT, 0, maximum ownership in MCLK cycles; 0 disables the watchdog; legal range 0..65535

Ports:
- MCLK  input  1  system clock; the block's only clock
- SRES  input  1  reset, asynchronous, active-low
- REQ  input  NREQ  per-master bus request, active-high, level
- BG  input  1  68000 bus grant pin, active-low, already synchronised to MCLK
- AS_i  input  1  68000 address strobe, active-low
- BGACK_i  input  1  wired BGACK bus, active-low
- BR_pull  output  1  1 = pull the BR line low
- BGACK_pull  output  1  1 = pull the BGACK line low
- GNT  output  NREQ  one-hot grant, active-high
- BUSY  output  1  1 while the FSM is outside IDLE
- TOUT  output  NREQ  one-cycle pulse on the index whose grant the watchdog revoked

## Operation

- FSM states: IDLE, ARB, OWN, REL. All outputs are registered.
- **IDLE**
  - If any REQ bit is 1, latch the winner index into `owner`, go to ARB and set BR_pull to 1.
- **Winner selection**
  - PRIO_MODE=0: lowest set index.
  - PRIO_MODE=1: first set index scanning upward from `rr_ptr`, modulo NREQ.
- **ARB**
  - BR_pull stays 1.
  - If REQ[owner] falls to 0, the request is cancelled: BR_pull goes to 0 and the FSM returns to IDLE. `rr_ptr` is unchanged.
  - If BG=0, AS_i=1 and BGACK_i=1 are all sampled in the same cycle, go to OWN. On that transition BGACK_pull=1, GNT[owner]=1, BR_pull=0 and the watchdog counter clears to 0.
  - Cancellation takes priority over the grant when both conditions hold in the same cycle.
- **OWN**
  - The counter increments each cycle and saturates at its maximum.
  - Release condition: REQ[owner]=0, or TIMEOUT≠0 and counter = TIMEOUT−1.
  - On release, go to REL with BGACK_pull=0 and GNT=0.
  - On a watchdog release, TOUT[owner]=1 for exactly that one cycle.
  - If REQ[owner]=0 and the watchdog fire in the same cycle, the release counts as normal and TOUT stays 0.
- **REL**
  - Lasts exactly one dead cycle with no grant and no pulls.
  - `rr_ptr` becomes (owner+1) mod NREQ, then the FSM goes to IDLE.
  - REQ is re-evaluated in IDLE only, so a timed-out master that still holds REQ competes again normally.
- **Counter width**: max(1, clog2(TIMEOUT+1)) bits.
- **Invariants**
  - GNT is always one-hot or zero.
  - GNT≠0 if and only if BGACK_pull=1.
  - BR_pull and BGACK_pull are never both 1.
- **Reset** (SRES=0, at any time, including mid-OWN):
  - FSM goes to IDLE; rr_ptr=0; counter=0.
  - BR_pull=0, BGACK_pull=0, GNT=0, BUSY=0, TOUT=0.
  - Outputs take these values immediately, without waiting for a clock edge.

## Timing

- **Request to BR_pull**: 1 MCLK after REQ is sampled in IDLE.
- **Grant acceptance**: BGACK_pull and GNT assert 1 MCLK after the cycle in which BG/AS_i/BGACK_i qualify. BR_pull falls on that same edge.
- **Release**: BGACK_pull and GNT fall 1 MCLK after REQ[owner]=0 is sampled.
- **Back-to-back handover**: minimum spacing between consecutive grants is 3 MCLK (REL, IDLE, ARB), plus the CPU's BG latency.
- **Watchdog**: with TIMEOUT=T, GNT is high for exactly T cycles.
- **BUSY**: 1 from the edge that enters ARB until the edge that enters IDLE.

## Test plan

- **Reset**: assert SRES=0 mid-OWN with NREQ=4 and GNT=4'b0010 -> all outputs go to 0 asynchronously; after release, IDLE with BUSY=0.
- **Fixed priority**: PRIO_MODE=0, REQ=4'b1010 in IDLE, CPU returns BG=0 two cycles later with AS_i=1 -> BR_pull=1 for 3 cycles, then GNT=4'b0010 and BGACK_pull=1; drop REQ[1] -> GNT=0 one cycle later, then GNT=4'b1000 no earlier than 3 cycles after that.
- **Round-robin**: PRIO_MODE=1, all four REQ held high, each owner drops its REQ after 5 cycles then re-raises it -> grant order is 0,1,2,3,0.
- **Bus busy**: BG=0 while AS_i=0 for 6 cycles -> no GNT while AS_i=0; GNT asserts 1 cycle after AS_i returns to 1.
- **Watchdog**: TIMEOUT=16, REQ[2] held forever -> GNT[2] high for exactly 16 cycles, TOUT=4'b0100 for 1 cycle, then the REL dead cycle and a re-grant of index 2.
- **Cancel**: REQ[3] drops while in ARB before BG arrives -> BR_pull=0 next cycle, GNT stays 0, rr_ptr unchanged; a simultaneous cancel and BG=0 produces no grant.
